// File: rtl/fpcvt_pipe.sv
// Pipelined two's-complement to compact float (S, E, F) converter with valid/ready flow control.
// Define FPCVT_ROUND_EN to enable round-half-up in the last stage; otherwise it truncates.
module fpcvt_pipe #(
  parameter int IN_W  = 13,
  parameter int EXP_W = 3,
  parameter int MAN_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_s,
  output logic [EXP_W-1:0] out_e,
  output logic [MAN_W-1:0] out_f,
  output logic             out_sat
);

  localparam int MW = IN_W - 1;
  localparam int PW = (MW > 1) ? $clog2(MW) : 1;

  if ((EXP_W < 1) || (MAN_W < 1) || (MAN_W > MW) ||
      ((IN_W - 1 - MAN_W) > (2 ** EXP_W - 1))) begin : gen_param_check
    $error("fpcvt_pipe: illegal IN_W/EXP_W/MAN_W combination");
  end

  // Stage valids and data
  logic             v1_q, v2_q, v3_q;
  logic             s1_q, sat1_q;
  logic [MW-1:0]    mag1_q;
  logic             s2_q, sat2_q, r2_q;
  logic [EXP_W-1:0] e2_q;
  logic [MAN_W-1:0] f2_q;
  logic             s3_q, sat3_q;
  logic [EXP_W-1:0] e3_q;
  logic [MAN_W-1:0] f3_q;

  logic load1, load2, load3;

  // Each stage loads when empty or when its downstream neighbour loads this cycle.
  always_comb begin
    load3 = !v3_q || out_ready;
    load2 = !v2_q || load3;
    load1 = !v1_q || load2;
  end

  assign in_ready = load1;

  // S1: sign-magnitude, most-negative input clamps to the all-ones magnitude
  logic          most_neg;
  logic [MW-1:0] mag_d;

  always_comb begin
    most_neg = (in_data == {1'b1, {MW{1'b0}}});
    mag_d    = in_data[IN_W-1] ? (~in_data[MW-1:0] + MW'(1)) : in_data[MW-1:0];
    if (most_neg) mag_d = '1;
  end

  // S2: leading-one extract
  logic [PW-1:0]    lead;
  logic [MW-1:0]    shifted;
  logic [MW-1:0]    rbits;
  logic [EXP_W-1:0] e2_d;
  logic [MAN_W-1:0] f2_d;
  logic             r2_d;

  always_comb begin
    lead = '0;
    for (int i = 0; i < MW; i++) begin
      if (mag1_q[i]) lead = PW'(i);
    end
    shifted = mag1_q;
    rbits   = '0;
    e2_d    = '0;
    f2_d    = mag1_q[MAN_W-1:0];
    r2_d    = 1'b0;
    if (int'(lead) >= MAN_W - 1) begin
      shifted = mag1_q >> (int'(lead) - (MAN_W - 1));
      e2_d    = EXP_W'(int'(lead) - (MAN_W - 1));
      f2_d    = shifted[MAN_W-1:0];
      if (int'(lead) >= MAN_W) begin
        rbits = mag1_q >> (int'(lead) - MAN_W);
        r2_d  = rbits[0];
      end
    end
  end

  // S3: round (optional) and saturate
  logic [EXP_W-1:0] e3_d;
  logic [MAN_W-1:0] f3_d;
  logic             sat3_d;

`ifdef FPCVT_ROUND_EN
  always_comb begin
    e3_d   = e2_q;
    f3_d   = f2_q;
    sat3_d = sat2_q;
    if (r2_q) begin
      if (f2_q != '1) begin
        f3_d = f2_q + MAN_W'(1);
      end else if (e2_q != '1) begin
        e3_d = e2_q + EXP_W'(1);
        f3_d = {1'b1, {(MAN_W-1){1'b0}}};
      end else begin
        e3_d   = '1;
        f3_d   = '1;
        sat3_d = 1'b1;
      end
    end
  end
`else
  logic unused_r2;
  assign unused_r2 = r2_q;

  always_comb begin
    e3_d   = e2_q;
    f3_d   = f2_q;
    sat3_d = sat2_q;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      s1_q   <= 1'b0;
      sat1_q <= 1'b0;
      mag1_q <= '0;
      s2_q   <= 1'b0;
      sat2_q <= 1'b0;
      r2_q   <= 1'b0;
      e2_q   <= '0;
      f2_q   <= '0;
      s3_q   <= 1'b0;
      sat3_q <= 1'b0;
      e3_q   <= '0;
      f3_q   <= '0;
    end else begin
      if (load1) v1_q <= in_valid;
      if (load1 && in_valid) begin
        s1_q   <= in_data[IN_W-1];
        sat1_q <= most_neg;
        mag1_q <= mag_d;
      end
      if (load2) v2_q <= v1_q;
      if (load2 && v1_q) begin
        s2_q   <= s1_q;
        sat2_q <= sat1_q;
        r2_q   <= r2_d;
        e2_q   <= e2_d;
        f2_q   <= f2_d;
      end
      if (load3) v3_q <= v2_q;
      if (load3 && v2_q) begin
        s3_q   <= s2_q;
        sat3_q <= sat3_d;
        e3_q   <= e3_d;
        f3_q   <= f3_d;
      end
    end
  end

  assign out_valid = v3_q;
  assign out_s     = s3_q;
  assign out_e     = e3_q;
  assign out_f     = f3_q;
  assign out_sat   = sat3_q;

endmodule

// File: tb/tb_fpcvt_pipe.sv
// Directed and streamed checks for fpcvt_pipe at default widths (13/3/5).
module tb_fpcvt_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_s;
  logic [2:0]  out_e;
  logic [4:0]  out_f;
  logic        out_sat;

  int n_checks = 0;
  int n_fail   = 0;
  int n_recv   = 0;
  logic [9:0] q[$];

  always #5 clk = ~clk;

  fpcvt_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_s    (out_s),
    .out_e    (out_e),
    .out_f    (out_f),
    .out_sat  (out_sat)
  );

  // Arithmetic reference: {s, e[2:0], f[4:0], sat}
  function automatic logic [9:0] model(input logic [12:0] d);
    int m, e, f, r;
    logic s, sat;
    s = d[12];
    if (d == 13'h1000) begin
      m = 4095; sat = 1'b1;
    end else begin
      m = s ? (8192 - int'(d)) : int'(d); sat = 1'b0;
    end
    e = 0;
    while ((m >> e) >= 32) e++;
    f = m >> e;
    r = (e > 0) ? ((m >> (e - 1)) & 1) : 0;
`ifdef FPCVT_ROUND_EN
    if (r == 1) begin
      f++;
      if (f == 32) begin
        if (e < 7) begin
          e++; f = 16;
        end else begin
          f = 31; sat = 1'b1;
        end
      end
    end
`endif
    return {s, 3'(e), 5'(f), sat};
  endfunction

  function automatic logic [9:0] outv();
    return {out_s, out_e, out_f, out_sat};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: settle, score output transfer, log input transfer, advance to next negedge.
  task automatic cycle();
    #1;
    if (out_valid && out_ready) begin
      check("pending_at_out", 16'(q.size() > 0), 16'd1);
      if (q.size() > 0) begin
        check("stream_result", 16'(outv()), 16'(q.pop_front()));
        n_recv++;
      end
    end
    if (in_valid && in_ready) q.push_back(model(in_data));
    @(negedge clk);
  endtask

  // Single conversion through an empty pipe, checking the 3-cycle latency.
  task automatic conv(input string tag, input logic [12:0] d, input logic s,
                      input logic [2:0] e, input logic [4:0] f, input logic sat);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_lat2"}, 16'(out_valid), 16'd0);
    @(negedge clk);
    check({tag, "_lat3"}, 16'(out_valid), 16'd1);
    check(tag, 16'(outv()), 16'({s, e, f, sat}));
    @(negedge clk);
  endtask

  logic [12:0] stall_d[4];
  logic [3:0]  rdy;
  logic [9:0]  snap;
  logic        seen;
  int          acc;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #1;
    check("reset_out_valid", 16'(out_valid), 16'd0);
    check("reset_outputs", 16'(outv()), 16'd0);
    check("reset_in_ready", 16'(in_ready), 16'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_out_valid", 16'(out_valid), 16'd0);

    conv("zero", 13'd0, 1'b0, 3'd0, 5'd0, 1'b0);
    conv("p422", 13'd422, 1'b0, 3'd4, 5'd26, 1'b0);
    conv("m56", 13'h1FC8, 1'b1, 3'd1, 5'd28, 1'b0);
`ifdef FPCVT_ROUND_EN
    conv("p63", 13'd63, 1'b0, 3'd2, 5'd16, 1'b0);
    conv("max_pos", 13'h0FFF, 1'b0, 3'd7, 5'd31, 1'b1);
`else
    conv("p63", 13'd63, 1'b0, 3'd1, 5'd31, 1'b0);
    conv("max_pos", 13'h0FFF, 1'b0, 3'd7, 5'd31, 1'b0);
`endif
    conv("most_neg", 13'h1000, 1'b1, 3'd7, 5'd31, 1'b1);
    conv("p100", 13'd100, 1'b0, 3'd2, 5'd25, 1'b0);

    // Random stream at full throughput
    n_recv = 0;
    for (int i = 0; i < 200; i++) begin
      in_valid = 1'b1;
      in_data  = 13'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 20 && q.size() > 0; k++) cycle();
    check("random_drain_empty", 16'(q.size()), 16'd0);
    check("random_count", 16'(n_recv), 16'd200);

    // Back-pressure: three fill the pipe, the fourth waits
    stall_d[0] = 13'd422;
    stall_d[1] = 13'h1FC8;
    stall_d[2] = 13'd63;
    stall_d[3] = 13'h1000;
    out_ready  = 1'b0;
    acc        = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = stall_d[k];
      #1;
      rdy[k] = in_ready;
      if (in_ready) begin
        q.push_back(model(in_data));
        acc++;
      end
      @(negedge clk);
    end
    check("stall_ready_pattern", 16'(rdy), 16'b0111);
    check("stall_accepted", 16'(acc), 16'd3);
    check("stall_out_valid", 16'(out_valid), 16'd1);
    check("stall_head", 16'(outv()), 16'(q[0]));
    snap = outv();
    @(negedge clk);
    check("stall_hold", 16'({out_valid, outv()}), 16'({1'b1, snap}));
    check("stall_in_ready", 16'(in_ready), 16'd0);
    out_ready = 1'b1;
    n_recv    = 0;
    cycle();
    in_valid = 1'b0;
    for (int k = 0; k < 10 && q.size() > 0; k++) cycle();
    check("stall_recv_count", 16'(n_recv), 16'd4);
    check("stall_queue_empty", 16'(q.size()), 16'd0);
    #1;
    check("stall_no_duplicate", 16'(out_valid), 16'd0);
    @(negedge clk);

    // Reset with two samples in flight
    in_valid = 1'b1;
    in_data  = 13'd300;
    @(negedge clk);
    in_data = 13'd500;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midreset_out_valid", 16'(out_valid), 16'd0);
    check("midreset_outputs", 16'(outv()), 16'd0);
    check("midreset_in_ready", 16'(in_ready), 16'd1);
    @(negedge clk);
    check("midreset_hold", 16'(out_valid), 16'd0);
    rst_n = 1'b1;
    q.delete();
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check("postreset_no_partial", 16'(seen), 16'd0);
    conv("postreset_p100", 13'd100, 1'b0, 3'd2, 5'd25, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
